instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the decoder and immediate generator: owns the PC, issues word reads to instruction memory over a req/ack handshake, and presents each instruction with its PC to decode under a valid/ready handshake.
- Accepts redirects (branch/JAL using the generated immediate, or JALR absolute target) from execute, and flags misaligned targets.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/pc_next_calc.sv | 34 +++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch slice.
//   fetch_state_t    : fetch FSM states
//   RESET_PC_DEFAULT : default reset PC (word-aligned)
//   NOP_INSTR        : ADDI x0,x0,0, shown on instr_out before the first fetch
//   REDIR_REL/ABS    : redir_sel encodings
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  localparam logic REDIR_REL = 1'b0;  // target = pc_out + redir_imm
  localparam logic REDIR_ABS = 1'b1;  // target = redir_target

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection for the fetch unit (purely combinational).
//   i_pc_out       : PC of the instruction being accepted
//   i_redir_valid  : take a redirect instead of the sequential PC
//   i_redir_sel    : REDIR_REL (pc + imm) or REDIR_ABS (target)
//   i_redir_imm    : sign-extended B/J immediate
//   i_redir_target : JALR target
//   o_next_pc      : next fetch address (adds wrap modulo 2^XLEN)
//   o_misaligned   : o_next_pc is not word-aligned
module pc_next_calc
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc_out,
  input  logic            i_redir_valid,
  input  logic            i_redir_sel,
  input  logic [XLEN-1:0] i_redir_imm,
  input  logic [XLEN-1:0] i_redir_target,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_redir_pc;

  // NOTE: continuous assigns cover every output on every path, so no latch can be inferred.
  assign w_seq_pc     = i_pc_out + XLEN'(4);
  assign w_redir_pc   = (i_redir_sel == REDIR_ABS) ? i_redir_target
                                                   : i_pc_out + i_redir_imm;
  assign o_next_pc    = i_redir_valid ? w_redir_pc : w_seq_pc;
  // A compressed-aligned (bit 1 set) target is also an error: word fetch only.
  assign o_misaligned = |o_next_pc[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads one instruction word at a time
// from instruction memory (req/ack) and hands it to decode (valid/ready).
// No prefetch: each instruction costs a FETCH cycle and a VALID cycle.
//   clk, rst_n                 : clock, async active-low reset
//   imem_req/addr/ack/rdata    : instruction memory read handshake
//   instr_valid/ready          : decode handshake
//   instr_out, pc_out, pc_plus4: fetched word, its PC, and PC+4 for links
//   redir_valid/sel/imm/target : redirect applied on the accept cycle
//   misalign_err               : sticky, set by a misaligned redirect target
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            redir_valid,
  input  logic            redir_sel,
  input  logic [XLEN-1:0] redir_imm,
  input  logic [XLEN-1:0] redir_target,
  output logic            misalign_err
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_imem_req;
  logic            r_instr_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc_out;
  logic            r_misalign_err;

  logic [XLEN-1:0] w_next_pc;
  logic            w_misaligned;

  pc_next_calc #(
    .XLEN(XLEN)
  ) u_pc_next_calc (
    .i_pc_out       (r_pc_out),
    .i_redir_valid  (redir_valid),
    .i_redir_sel    (redir_sel),
    .i_redir_imm    (redir_imm),
    .i_redir_target (redir_target),
    .o_next_pc      (w_next_pc),
    .o_misaligned   (w_misaligned)
  );

  // NOTE: state updates use non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_pc           <= RESET_PC;
      r_imem_req     <= 1'b0;
      r_instr_valid  <= 1'b0;
      r_instr        <= NOP_INSTR;
      r_pc_out       <= RESET_PC;
      r_misalign_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_imem_req <= 1'b1;
          r_state    <= ST_FETCH;
        end

        ST_FETCH: begin
          if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_pc_out      <= r_pc;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= ST_VALID;
          end
        end

        // instr_valid is high exactly in this state, so ready here is the
        // accept cycle and the only time redir_* is looked at.
        ST_VALID: begin
          if (instr_ready) begin
            r_instr_valid <= 1'b0;
            if (w_misaligned) begin
              r_misalign_err <= 1'b1;
              r_state        <= ST_ERR;
            end else begin
              r_pc       <= w_next_pc;
              r_imem_req <= 1'b1;
              r_state    <= ST_FETCH;
            end
          end
        end

        ST_ERR: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req     = r_imem_req;
  assign imem_addr    = r_pc;
  assign instr_valid  = r_instr_valid;
  assign instr_out    = r_instr;
  assign pc_out       = r_pc_out;
  assign pc_plus4     = r_pc_out + XLEN'(4);
  assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A second instance with
// RESET_PC = 0xFFFF_FFFC covers PC wrap-around.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ack = 1'b0;
  logic        ack_w = 1'b0;
  logic [31:0] rdata = '0;
  logic        ready = 1'b1;
  logic        redir_valid = 1'b0;
  logic        redir_sel = 1'b0;
  logic [31:0] redir_imm = '0;
  logic [31:0] redir_target = '0;

  logic        req, valid, merr;
  logic [31:0] addr, instr, pc, pc4;
  logic        req_w, valid_w, merr_w;
  logic [31:0] addr_w, instr_w, pc_w, pc4_w;

  sb_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
    .instr_valid(valid), .instr_ready(ready), .instr_out(instr),
    .pc_out(pc), .pc_plus4(pc4),
    .redir_valid(redir_valid), .redir_sel(redir_sel),
    .redir_imm(redir_imm), .redir_target(redir_target),
    .misalign_err(merr)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req_w), .imem_addr(addr_w), .imem_ack(ack_w), .imem_rdata(rdata),
    .instr_valid(valid_w), .instr_ready(ready), .instr_out(instr_w),
    .pc_out(pc_w), .pc_plus4(pc4_w),
    .redir_valid(redir_valid), .redir_sel(redir_sel),
    .redir_imm(redir_imm), .redir_target(redir_target),
    .misalign_err(merr_w)
  );

  // Reset both instances; returns at the negedge where the main DUT is in FETCH.
  task automatic do_reset();
    ack = 1'b0; ack_w = 1'b0; ready = 1'b1; redir_valid = 1'b0;
    sb.delete();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Wait (bounded) for a request, ack it with data and record the expectation.
  // Returns at the following negedge with ack dropped.
  task automatic serve(input logic [31:0] exp_pc, input logic [31:0] data, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      sb.push_back('{pc: exp_pc, instr: data});
      ack = 1'b1; rdata = data;
      @(negedge clk);
      ack = 1'b0;
    end
  endtask

  task automatic pop_expected(output sb_t e, output bit ok);
    ok = (sb.size() != 0);
    e  = ok ? sb.pop_front() : '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", req); end
    n_tests++; if (addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h exp 0", addr); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", valid); end
    n_tests++; if (instr !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h exp %h", instr, NOP); end
    n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h exp 0", pc); end
    n_tests++; if (merr !== 1'b0) begin n_fail++; $display("FAIL rst_merr: got %b exp 0", merr); end
    n_tests++; if (addr_w !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rst_addr_w: got %h exp fffffffc", addr_w); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sequential();
    bit ok; sb_t e;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (req !== 1'b1 || addr !== 32'(4 * i))
        begin n_fail++; $display("FAIL seq_fetch%0d: got req=%b addr=%h exp req=1 addr=%h", i, req, addr, 32'(4 * i)); end
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL seq_valid_low%0d: got %b exp 0", i, valid); end
      serve(32'(4 * i), 32'h0010_0093 + 32'(i << 20), ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL seq_req_timeout%0d: got none exp req", i); end
      pop_expected(e, ok);
      n_tests++; if (valid !== 1'b1 || !ok || pc !== e.pc || instr !== e.instr || pc4 !== e.pc + 32'd4)
        begin n_fail++; $display("FAIL seq_out%0d: got v=%b pc=%h instr=%h pc4=%h exp pc=%h instr=%h", i, valid, pc, instr, pc4, e.pc, e.instr); end
      @(negedge clk);
    end
  endtask

  task automatic test_wait_states();
    bit ok; sb_t e;
    do_reset();
    serve(32'h0, NOP, ok);
    pop_expected(e, ok);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (req !== 1'b1 || addr !== 32'h4 || valid !== 1'b0)
        begin n_fail++; $display("FAIL wait_hold%0d: got req=%b addr=%h v=%b exp 1/00000004/0", k, req, addr, valid); end
      if (k < 3) @(negedge clk);
    end
    serve(32'h4, 32'h0020_0113, ok);
    pop_expected(e, ok);
    n_tests++; if (!ok || valid !== 1'b1 || pc !== e.pc || instr !== e.instr)
      begin n_fail++; $display("FAIL wait_out: got v=%b pc=%h instr=%h exp pc=%h instr=%h", valid, pc, instr, e.pc, e.instr); end
  endtask

  task automatic test_stall();
    bit ok; sb_t e;
    do_reset();
    ready = 1'b0;
    serve(32'h0, 32'h00A0_0093, ok);
    pop_expected(e, ok);
    // Memory ack and redirect noise during the stall must both be ignored.
    redir_valid = 1'b1; redir_sel = 1'b1; redir_target = 32'h0000_0103;
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (!ok || valid !== 1'b1 || instr !== e.instr || pc !== e.pc || req !== 1'b0 || pc4 !== e.pc + 32'd4)
        begin n_fail++; $display("FAIL stall%0d: got v=%b instr=%h pc=%h req=%b pc4=%h exp v=1 instr=%h pc=%h", k, valid, instr, pc, req, pc4, e.instr, e.pc); end
      @(negedge clk);
    end
    ack = 1'b0; redir_valid = 1'b0; ready = 1'b1;
    @(negedge clk);
    n_tests++; if (req !== 1'b1 || addr !== 32'h4 || merr !== 1'b0)
      begin n_fail++; $display("FAIL stall_release: got req=%b addr=%h merr=%b exp 1/00000004/0", req, addr, merr); end
  endtask

  task automatic test_redirect();
    bit ok; sb_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      serve(32'(4 * i), NOP, ok);
      pop_expected(e, ok);
      n_tests++; if (!ok || pc !== e.pc)
        begin n_fail++; $display("FAIL redir_pre%0d: got pc=%h exp %h", i, pc, e.pc); end
      if (i < 4) @(negedge clk);
    end
    // Branch at 0x10 with offset -8.
    redir_valid = 1'b1; redir_sel = 1'b0; redir_imm = 32'hFFFF_FFF8;
    @(negedge clk);
    redir_valid = 1'b0;
    n_tests++; if (req !== 1'b1 || addr !== 32'h8)
      begin n_fail++; $display("FAIL branch_target: got req=%b addr=%h exp 1/00000008", req, addr); end
    serve(32'h8, 32'h2000_00E7, ok);
    pop_expected(e, ok);
    n_tests++; if (!ok || pc !== e.pc || instr !== e.instr)
      begin n_fail++; $display("FAIL branch_land: got pc=%h instr=%h exp %h %h", pc, instr, e.pc, e.instr); end
    // Aligned JALR.
    redir_valid = 1'b1; redir_sel = 1'b1; redir_target = 32'h0000_0200; redir_imm = 32'h0000_0040;
    @(negedge clk);
    redir_valid = 1'b0;
    n_tests++; if (req !== 1'b1 || addr !== 32'h200 || merr !== 1'b0)
      begin n_fail++; $display("FAIL jalr_target: got req=%b addr=%h merr=%b exp 1/00000200/0", req, addr, merr); end
  endtask

  task automatic test_misalign();
    bit ok; sb_t e;
    do_reset();
    serve(32'h0, 32'h0000_0067, ok);
    pop_expected(e, ok);
    redir_valid = 1'b1; redir_sel = 1'b1; redir_target = 32'h0000_0102;
    @(negedge clk);
    redir_valid = 1'b0;
    n_tests++; if (merr !== 1'b1 || valid !== 1'b0 || req !== 1'b0)
      begin n_fail++; $display("FAIL misalign_enter: got merr=%b v=%b req=%b exp 1/0/0", merr, valid, req); end
    ack = 1'b1;
    repeat (4) @(negedge clk);
    ack = 1'b0;
    n_tests++; if (merr !== 1'b1 || valid !== 1'b0 || req !== 1'b0 || addr !== 32'h0)
      begin n_fail++; $display("FAIL misalign_stuck: got merr=%b v=%b req=%b addr=%h exp 1/0/0/00000000", merr, valid, req, addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    n_tests++; if (req_w !== 1'b1 || addr_w !== 32'hFFFF_FFFC)
      begin n_fail++; $display("FAIL wrap_first: got req=%b addr=%h exp 1/fffffffc", req_w, addr_w); end
    ack_w = 1'b1; rdata = NOP;
    @(negedge clk);
    ack_w = 1'b0;
    n_tests++; if (valid_w !== 1'b1 || pc_w !== 32'hFFFF_FFFC || pc4_w !== 32'h0)
      begin n_fail++; $display("FAIL wrap_valid: got v=%b pc=%h pc4=%h exp 1/fffffffc/00000000", valid_w, pc_w, pc4_w); end
    @(negedge clk);
    n_tests++; if (req_w !== 1'b1 || addr_w !== 32'h0 || merr_w !== 1'b0)
      begin n_fail++; $display("FAIL wrap_second: got req=%b addr=%h merr=%b exp 1/00000000/0", req_w, addr_w, merr_w); end
  endtask

  task automatic test_async_reset();
    do_reset();
    n_tests++; if (merr !== 1'b0 || req !== 1'b1)
      begin n_fail++; $display("FAIL areset_pre: got merr=%b req=%b exp 0/1", merr, req); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (req !== 1'b0 || valid !== 1'b0 || addr !== 32'h0)
      begin n_fail++; $display("FAIL areset_immediate: got req=%b v=%b addr=%h exp 0/0/0", req, valid, addr); end
    @(negedge clk);
    @(negedge clk);
    ack = 1'b1; rdata = 32'hCAFE_F00D;
    rst_n = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_tests++; if (valid !== 1'b0 || instr !== NOP || pc !== 32'h0 || req !== 1'b1 || addr !== 32'h0)
      begin n_fail++; $display("FAIL areset_late_ack: got v=%b instr=%h pc=%h req=%b addr=%h exp 0/%h/0/1/0", valid, instr, pc, req, addr, NOP); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall();
    test_redirect();
    test_misalign();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
